// File: rtl/coin_acceptor.sv
// coin_acceptor: front end between two raw coin sensors and the vending FSM.
// Each sensor is synchronized, debounced and turned into a single registered
// accept pulse (five_in / ten_in) or a reject pulse (coin_reject).
// After a coin is released, a lockout interval ignores the sensors.
//
// Optional feature: define COIN_TOTAL_EN to add the clear_total input and a
// saturating 8-bit running total, coin_total, of accepted value.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       enable,
`ifdef COIN_TOTAL_EN
  input  logic       clear_total,
  output logic [7:0] coin_total,
`endif
  output logic       five_in,
  output logic       ten_in,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_DEBOUNCE     = 2'd1,
    S_WAIT_RELEASE = 2'd2,
    S_LOCKOUT      = 2'd3
  } state_t;

  // The IDLE sample counts as the first one, so acceptance happens when the
  // count already holds DEBOUNCE_CYCLES-1 and one more good sample arrives.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LK_INIT = 8'(LOCKOUT_CYCLES);

  logic   r_s5_meta;
  logic   r_s5;
  logic   r_s10_meta;
  logic   r_s10;

  state_t r_state;
  logic [7:0] r_cnt;
  logic   r_is10;
  logic   r_five;
  logic   r_ten;
  logic   r_reject;
  logic   r_busy;

  logic   w_coin_hi;
  logic   w_other_hi;

  // Two-flop synchronizers on both raw sensors; only the second flop is used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s5_meta  <= 1'b0;
      r_s5       <= 1'b0;
      r_s10_meta <= 1'b0;
      r_s10      <= 1'b0;
    end else begin
      r_s5_meta  <= coin5_raw;
      r_s5       <= r_s5_meta;
      r_s10_meta <= coin10_raw;
      r_s10      <= r_s10_meta;
    end
  end

  // Select the latched coin's sensor and the opposite sensor for debouncing.
  always_comb begin
    w_coin_hi  = r_is10 ? r_s10 : r_s5;
    w_other_hi = r_is10 ? r_s5  : r_s10;
  end

  // Main FSM: one shared counter serves both debounce and lockout timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_is10   <= 1'b0;
      r_five   <= 1'b0;
      r_ten    <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_five   <= 1'b0;
      r_ten    <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_s5 ^ r_s10) begin
            r_is10  <= r_s10;
            r_cnt   <= 8'd1;
            r_state <= S_DEBOUNCE;
            r_busy  <= 1'b1;
          end else if (r_s5 && r_s10) begin
            r_reject <= 1'b1;
            r_state  <= S_WAIT_RELEASE;
            r_busy   <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (w_coin_hi && !w_other_hi) begin
            if (r_cnt == DB_LAST) begin
              // enable matters only here, at the acceptance point
              if (enable) begin
                r_five <= ~r_is10;
                r_ten  <= r_is10;
              end else begin
                r_reject <= 1'b1;
              end
              r_cnt   <= 8'd0;
              r_state <= S_WAIT_RELEASE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            // glitch or second coin during debounce: drop it silently
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT_RELEASE: begin
          if (!r_s5 && !r_s10) begin
            r_cnt   <= LK_INIT;
            r_state <= S_LOCKOUT;
          end
        end
        S_LOCKOUT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign five_in     = r_five;
  assign ten_in      = r_ten;
  assign coin_reject = r_reject;
  assign busy        = r_busy;

`ifdef COIN_TOTAL_EN
  logic [7:0] r_total;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Running total of accepted value; clear wins over a coincident add.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_total <= 8'd0;
    end else if (clear_total) begin
      r_total <= 8'd0;
    end else if (r_five) begin
      r_total <= sat_add8(r_total, 8'd5);
    end else if (r_ten) begin
      r_total <= sat_add8(r_total, 8'd10);
    end
  end

  assign coin_total = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor with default parameters. Expected pulses are
// queued (kind + clock edge) when stimulus is driven; a negedge monitor pops
// and compares them whenever the DUT emits a pulse.
module tb_coin_acceptor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic coin5_raw = 1'b0;
  logic coin10_raw = 1'b0;
  logic enable = 1'b1;
  logic five_in;
  logic ten_in;
  logic coin_reject;
  logic busy;
`ifdef COIN_TOTAL_EN
  logic clear_total = 1'b0;
  logic [7:0] coin_total;
`endif

  typedef struct {
    int kind;     // 0 = five_in, 1 = ten_in, 2 = coin_reject
    int edge_at;  // posedge count after which the pulse is visible
  } exp_t;

  exp_t q[$];
  int edge_n = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit prev_any = 1'b0;

  coin_acceptor dut (
    .clock       (clock),
    .reset       (reset),
    .coin5_raw   (coin5_raw),
    .coin10_raw  (coin10_raw),
    .enable      (enable),
`ifdef COIN_TOTAL_EN
    .clear_total (clear_total),
    .coin_total  (coin_total),
`endif
    .five_in     (five_in),
    .ten_in      (ten_in),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clock) begin : mon
    int kind;
    exp_t e;
    if (five_in | ten_in | coin_reject) begin
      kind = five_in ? 0 : (ten_in ? 1 : 2);
      n_checks++;
      if ($countones({five_in, ten_in, coin_reject}) != 1) begin
        n_fail++;
        $display("FAIL exclusive_pulses: got five=%0b ten=%0b rej=%0b, required one-hot", five_in, ten_in, coin_reject);
      end
      n_checks++;
      if (prev_any) begin
        n_fail++;
        $display("FAIL consecutive_pulse: got pulse at edge %0d right after another, required gap", edge_n);
      end
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at edge %0d, required none", kind, edge_n);
      end else begin
        e = q.pop_front();
        if (e.kind !== kind || e.edge_at !== edge_n) begin
          n_fail++;
          $display("FAIL pulse_match: got kind %0d at edge %0d, required kind %0d at edge %0d", kind, edge_n, e.kind, e.edge_at);
        end
      end
    end
    prev_any = five_in | ten_in | coin_reject;
  end

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({five_in, ten_in, coin_reject, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000", {five_in, ten_in, coin_reject, busy});
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if ({five_in, ten_in, coin_reject, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_held: got %b, required 0000", {five_in, ten_in, coin_reject, busy});
    end
`ifdef COIN_TOTAL_EN
    n_checks++;
    if (coin_total !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_total: got %0d, required 0", coin_total);
    end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_accept5();
    int t0, t1;
    @(negedge clock);
    t0 = edge_n;
    enable = 1'b1;
    coin5_raw = 1'b1;
    q.push_back('{0, t0 + 6});
    wait_edge(t0 + 2);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL accept5_busy_pre: got %b, required 0", busy); end
    wait_edge(t0 + 3);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL accept5_busy_start: got %b, required 1", busy); end
    wait_edge(t0 + 20);
    coin5_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL accept5_lockout_busy: got %b, required 1", busy); end
    wait_edge(t1 + 11);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL accept5_idle: got %b, required 0", busy); end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL accept5_missing: got %0d pending, required 0", q.size()); end
  endtask

  task automatic test_glitch();
    int t0;
    @(negedge clock);
    t0 = edge_n;
    coin10_raw = 1'b1;
    wait_edge(t0 + 2);
    coin10_raw = 1'b0;
    wait_edge(t0 + 4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_debounce_busy: got %b, required 1", busy); end
    wait_edge(t0 + 5);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b, required 0", busy); end
    wait_edge(t0 + 15);
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL glitch_queue: got %0d pending, required 0", q.size()); end
  endtask

  task automatic test_both();
    int t0, t1;
    @(negedge clock);
    t0 = edge_n;
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    q.push_back('{2, t0 + 3});
    wait_edge(t0 + 10);
    coin5_raw = 1'b0;
    wait_edge(t0 + 20);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL both_hold_busy: got %b, required 1", busy); end
    coin10_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL both_lockout_busy: got %b, required 1", busy); end
    wait_edge(t1 + 11);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL both_idle: got %b, required 0", busy); end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL both_missing: got %0d pending, required 0", q.size()); end
  endtask

  task automatic test_enable();
    int t0, t1;
    // enable low exactly at the acceptance edge -> reject
    @(negedge clock);
    t0 = edge_n;
    coin10_raw = 1'b1;
    q.push_back('{2, t0 + 6});
    wait_edge(t0 + 5);
    enable = 1'b0;
    wait_edge(t0 + 6);
    enable = 1'b1;
    wait_edge(t0 + 12);
    coin10_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 12);
    n_checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL enable_off_reject: got pending=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
    // enable low only during debounce -> still accepted
    t0 = edge_n;
    coin10_raw = 1'b1;
    q.push_back('{1, t0 + 6});
    wait_edge(t0 + 3);
    enable = 1'b0;
    wait_edge(t0 + 5);
    enable = 1'b1;
    wait_edge(t0 + 12);
    coin10_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 12);
    n_checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL enable_midway_accept: got pending=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask

  task automatic test_lockout();
    int t0, t1;
    @(negedge clock);
    t0 = edge_n;
    coin5_raw = 1'b1;
    q.push_back('{0, t0 + 6});
    wait_edge(t0 + 10);
    coin5_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 3);
    coin10_raw = 1'b1;
    wait_edge(t1 + 9);
    coin10_raw = 1'b0;
    wait_edge(t1 + 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL lockout_busy: got %b, required 1", busy); end
    wait_edge(t1 + 11);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL lockout_idle: got %b, required 0", busy); end
    wait_edge(t1 + 20);
    n_checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL lockout_ignore: got pending=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int t0, t1, tr;
    @(negedge clock);
    t0 = edge_n;
    coin5_raw = 1'b1;
    wait_edge(t0 + 4);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({five_in, ten_in, coin_reject, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b, required 0000", {five_in, ten_in, coin_reject, busy});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tr = edge_n;
    q.push_back('{0, tr + 6});
    wait_edge(tr + 12);
    coin5_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 12);
    n_checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_reinsert: got pending=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    @(negedge clock);
    t0 = edge_n;
    coin10_raw = 1'b1;
    q.push_back('{1, t0 + 6});
    wait_edge(t0 + 8);
    coin10_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 11);
    t2 = edge_n;
    coin5_raw = 1'b1;
    q.push_back('{0, t2 + 6});
    wait_edge(t2 + 8);
    coin5_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 12);
    n_checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back: got pending=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask

`ifdef COIN_TOTAL_EN
  task automatic ten_coin(output int accept_edge);
    int t0, t1;
    t0 = edge_n;
    coin10_raw = 1'b1;
    q.push_back('{1, t0 + 6});
    accept_edge = t0 + 6;
    wait_edge(t0 + 8);
    coin10_raw = 1'b0;
    t1 = edge_n;
    wait_edge(t1 + 12);
  endtask

  task automatic test_total();
    int exp_tot, pe, t0;
    @(negedge clock);
    clear_total = 1'b1;
    @(negedge clock);
    clear_total = 1'b0;
    n_checks++;
    if (coin_total !== 8'd0) begin n_fail++; $display("FAIL total_clear: got %0d, required 0", coin_total); end
    exp_tot = 0;
    for (int i = 0; i < 26; i++) begin
      ten_coin(pe);
      exp_tot = (exp_tot + 10 > 255) ? 255 : exp_tot + 10;
      n_checks++;
      if (coin_total !== 8'(exp_tot)) begin
        n_fail++; $display("FAIL total_coin%0d: got %0d, required %0d", i, coin_total, exp_tot);
      end
    end
    // clear in the same cycle as ten_in wins over the add
    t0 = edge_n;
    coin10_raw = 1'b1;
    q.push_back('{1, t0 + 6});
    wait_edge(t0 + 6);
    clear_total = 1'b1;
    wait_edge(t0 + 7);
    clear_total = 1'b0;
    n_checks++;
    if (coin_total !== 8'd0) begin n_fail++; $display("FAIL total_clear_priority: got %0d, required 0", coin_total); end
    coin10_raw = 1'b0;
    wait_edge(t0 + 20);
    ten_coin(pe);
    n_checks++;
    if (coin_total !== 8'd10) begin n_fail++; $display("FAIL total_after_clear: got %0d, required 10", coin_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_accept5();
    test_glitch();
    test_both();
    test_enable();
    test_lockout();
    test_reset_mid();
    test_back_to_back();
`ifdef COIN_TOTAL_EN
    test_total();
`endif
    repeat (5) @(negedge clock);
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL final_queue: got %0d pending, required 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at edge %0d, required completion", edge_n);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized high samples needed to accept a coin; legal range 2..255.
REQ-002 Parameter LOCKOUT_CYCLES, default 8: cycles ignored after a coin is released; legal range 1..255.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coin5_raw  input  1  raw, asynchronous 5-unit coin sensor; high while a coin is present.
REQ-006 coin10_raw  input  1  raw, asynchronous 10-unit coin sensor; high while a coin is present.
REQ-007 enable  input  1  accept coins when high; coins are rejected when low.
REQ-008 five_in  output  1  registered one-cycle pulse per accepted 5-unit coin; feeds the vending FSM five_in.
REQ-009 ten_in  output  1  registered one-cycle pulse per accepted 10-unit coin; feeds the vending FSM ten_in.
REQ-010 coin_reject  output  1  registered one-cycle pulse per rejected coin.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer; the FSM uses only the second flop (s5, s10).
REQ-013 FSM states: IDLE, DEBOUNCE, WAIT_RELEASE, LOCKOUT.
REQ-014 IDLE: exactly one of s5/s10 high -> latch the coin type, set the sample count to 1, go to DEBOUNCE. Both high -> pulse coin_reject, go to WAIT_RELEASE. Neither high -> stay.
REQ-015 DEBOUNCE, each cycle: latched input high and the other input low -> increment the count. Otherwise -> return to IDLE with no output pulse (glitch discard).
REQ-016 On reaching DEBOUNCE_CYCLES samples, if enable is high, assert five_in or ten_in per the latched type for exactly one cycle; otherwise pulse coin_reject. Then go to WAIT_RELEASE.
REQ-017 Latency: with a raw input stable high from clock edge 1, the accept pulse is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
REQ-018 WAIT_RELEASE: stay while s5 or s10 is high; when both are low, load the lockout counter with LOCKOUT_CYCLES and go to LOCKOUT.
REQ-019 LOCKOUT: decrement each cycle and ignore all inputs (no pulses); go to IDLE when the counter reaches 0.
REQ-020 Invariants: five_in, ten_in and coin_reject are mutually exclusive; at most one pulse per coin insertion; no two pulses in consecutive cycles.
REQ-021 enable is sampled only at the acceptance point (REQ-016); enable changes at other times have no effect.

Reset
REQ-022 Reset SHALL immediately clear the synchronizers and counters, set the FSM to IDLE, and drive five_in, ten_in, coin_reject and busy to 0.
REQ-023 Reset mid-DEBOUNCE SHALL discard the coin with no pulse. After release, a coin still present is processed as a new insertion.

Configuration
REQ-024 Macro COIN_TOTAL_EN defined: the block adds input clear_total (1 bit) and output coin_total (8 bits, registered).
REQ-025 With COIN_TOTAL_EN, coin_total adds 5 or 10 on each accept pulse and saturates at 255.
REQ-026 With COIN_TOTAL_EN, clear_total forces coin_total to 0 and takes priority over a simultaneous add. Reset also clears coin_total.
REQ-027 Macro COIN_TOTAL_EN undefined: the clear_total and coin_total ports and their logic are absent; all other behaviour is identical.

Verification
REQ-028 Default parameters, enable=1, coin5_raw high for 20 cycles -> one five_in pulse at edge 6; busy falls LOCKOUT_CYCLES cycles after the synchronized release.
REQ-029 coin10_raw high for 2 cycles, then low -> no pulses; FSM returns to IDLE.
REQ-030 coin5_raw and coin10_raw rise together -> one coin_reject pulse, no five_in/ten_in; busy held until both are released, then through lockout.
REQ-031 enable=0 at the acceptance point, coin10_raw held high -> one coin_reject pulse, no ten_in.
REQ-032 A second coin inserted during LOCKOUT -> ignored. Reset asserted in DEBOUNCE -> all outputs 0 at once, no pulse.
REQ-033 COIN_TOTAL_EN defined: 26 accepted 10-unit coins -> coin_total saturates at 255. clear_total asserted in the same cycle as ten_in -> coin_total = 0.
